// File: rtl/fma_round_pipe.sv
// Two-stage IEEE-754 double rounding pipeline that sits after the FMA normalization shifter.
// Stage 1 registers the round-increment decision. Stage 2 applies it and registers the final result and flags.
module fma_round_pipe #(
    parameter int FRACW = 52,
    parameter int EXPW  = 13,
    parameter int EMAX  = 2047
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FRACW+1:0] in_v,
    input  logic [EXPW-1:0]  in_exp,
    input  logic             in_sign,
    input  logic [2:0]       in_frm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FRACW-1:0] out_frac,
    output logic [10:0]      out_exp,
    output logic             out_sign,
    output logic [2:0]       out_flags
);

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } frm_e;

    logic             s1_valid, s2_valid;
    logic [FRACW-1:0] s1_frac;
    logic [EXPW-1:0]  s1_exp;
    logic             s1_sign;
    logic [2:0]       s1_frm;
    logic             s1_inc;
    logic             s1_nx;

    logic s1_adv, s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // The increment decision looks only at L, R, S, the sign and the rounding mode.
    logic rnd_l, rnd_r, rnd_s, inc_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no path infers a latch.
        inc_d = 1'b0;
        rnd_l = in_v[2];
        rnd_r = in_v[1];
        rnd_s = in_v[0];
        case (in_frm)
            RTZ:     inc_d = 1'b0;
            RDN:     inc_d = in_sign & (rnd_r | rnd_s);
            RUP:     inc_d = ~in_sign & (rnd_r | rnd_s);
            RMM:     inc_d = rnd_r;
            default: inc_d = rnd_r & (rnd_s | rnd_l);
        endcase
    end

    // Stage 2 combinational datapath: add the increment, propagate a carry into the exponent, and saturate.
    logic [FRACW:0]   sum;
    logic             carry;
    logic [EXPW:0]    exp_inc;
    logic             ovf;
    logic             to_inf;
    logic [FRACW-1:0] frac_d;
    logic [10:0]      exp_d;
    logic [2:0]       flags_d;

    always_comb begin
        sum     = {1'b0, s1_frac} + (FRACW+1)'(s1_inc);
        carry   = sum[FRACW];
        exp_inc = {1'b0, s1_exp} + (EXPW+1)'(carry);
        ovf     = exp_inc >= (EXPW+1)'(EMAX);

        // Directed modes that round away from infinity saturate to max finite on overflow.
        case (s1_frm)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = s1_sign;
            RUP:     to_inf = ~s1_sign;
            default: to_inf = 1'b1;
        endcase

        frac_d  = carry ? '0 : sum[FRACW-1:0];
        exp_d   = exp_inc[10:0];
        flags_d = {1'b0, (s1_exp == '0) & s1_nx & ~carry, s1_nx};
        if (ovf) begin
            frac_d  = to_inf ? '0 : '1;
            exp_d   = to_inf ? 11'(EMAX) : 11'(EMAX - 1);
            flags_d = 3'b101;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_frac   <= '0;
            s1_exp    <= '0;
            s1_sign   <= 1'b0;
            s1_frm    <= '0;
            s1_inc    <= 1'b0;
            s1_nx     <= 1'b0;
            out_frac  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_flags <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so stage 2 samples the old stage 1 contents.
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_frac <= in_v[FRACW+1:2];
                    s1_exp  <= in_exp;
                    s1_sign <= in_sign;
                    s1_frm  <= in_frm;
                    s1_inc  <= inc_d;
                    s1_nx   <= in_v[1] | in_v[0];
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_frac  <= frac_d;
                    out_exp   <= exp_d;
                    out_sign  <= s1_sign;
                    out_flags <= flags_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fma_round_pipe.sv
// Directed bench for fma_round_pipe. Rounding vectors use hand-computed results.
// Handshake scenarios check ordering, stalls, flush and reset against an occupancy count.
module tb_fma_round_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [53:0] in_v;
    logic [12:0] in_exp;
    logic        in_sign;
    logic [2:0]  in_frm;
    logic        out_valid;
    logic        out_ready;
    logic [51:0] out_frac;
    logic [10:0] out_exp;
    logic        out_sign;
    logic [2:0]  out_flags;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [51:0] ONES = {52{1'b1}};

    fma_round_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_v(in_v), .in_exp(in_exp),
        .in_sign(in_sign), .in_frm(in_frm),
        .out_valid(out_valid), .out_ready(out_ready), .out_frac(out_frac),
        .out_exp(out_exp), .out_sign(out_sign), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Issue one op into an empty pipe and return the first result, with its latency in cycles.
    task automatic run_op(input logic [51:0] f, input logic r, input logic s, input logic [12:0] e,
                          input logic sg, input logic [2:0] fm,
                          output logic [51:0] rf, output logic [10:0] re, output logic rs,
                          output logic [2:0] rfl, output int lat);
        @(negedge clk);
        in_v = {f, r, s}; in_exp = e; in_sign = sg; in_frm = fm;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rf = out_frac; re = out_exp; rs = out_sign; rfl = out_flags;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; flush = 1'b0; out_ready = $urandom_range(1, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_v = {$urandom(), $urandom()}; in_exp = 13'($urandom());
            in_sign = 1'($urandom()); in_frm = 3'($urandom());
            #7;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (out_flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", out_flags); end
        n_cmp++;
        if ({out_frac, out_exp, out_sign} !== 64'd0) begin
            n_bad++; $display("FAIL reset_data got %h/%0d/%b want 0/0/0", out_frac, out_exp, out_sign);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rne;
        logic [51:0] f; logic [10:0] e; logic sg; logic [2:0] fl; int lat;
        // L=1, R=1, S=0: the tie rounds up to the even value.
        run_op(52'h1, 1'b1, 1'b0, 13'd1023, 1'b0, 3'b000, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h2, 11'd1023, 3'b001}) begin
            n_bad++; $display("FAIL rne_tie_up got %h/%0d/%b want 2/1023/001", f, e, fl);
        end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL latency got %0d want 2", lat); end
        // L=0: the tie stays on the even value.
        run_op(52'h2, 1'b1, 1'b0, 13'd1023, 1'b1, 3'b000, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl, sg} !== {52'h2, 11'd1023, 3'b001, 1'b1}) begin
            n_bad++; $display("FAIL rne_tie_even got %h/%0d/%b/%b want 2/1023/001/1", f, e, fl, sg);
        end
        // Mode 111 is treated as RNE.
        run_op(52'h1, 1'b1, 1'b0, 13'd5, 1'b0, 3'b111, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h2, 11'd5, 3'b001}) begin
            n_bad++; $display("FAIL frm7_as_rne got %h/%0d/%b want 2/5/001", f, e, fl);
        end
    endtask

    task automatic test_carry;
        logic [51:0] f; logic [10:0] e; logic sg; logic [2:0] fl; int lat;
        run_op(ONES, 1'b1, 1'b1, 13'd1023, 1'b0, 3'b011, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h0, 11'd1024, 3'b001}) begin
            n_bad++; $display("FAIL carry_rup got %h/%0d/%b want 0/1024/001", f, e, fl);
        end
        run_op(ONES, 1'b1, 1'b1, 13'd1023, 1'b0, 3'b001, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {ONES, 11'd1023, 3'b001}) begin
            n_bad++; $display("FAIL carry_rtz got %h/%0d/%b want fffffffffffff/1023/001", f, e, fl);
        end
        // An exact input raises no flags and is not changed.
        run_op(52'h12345, 1'b0, 1'b0, 13'd700, 1'b1, 3'b100, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h12345, 11'd700, 3'b000}) begin
            n_bad++; $display("FAIL exact got %h/%0d/%b want 12345/700/000", f, e, fl);
        end
    endtask

    task automatic test_overflow;
        logic [51:0] f; logic [10:0] e; logic sg; logic [2:0] fl; int lat;
        run_op(ONES, 1'b1, 1'b0, 13'd2046, 1'b1, 3'b000, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h0, 11'd2047, 3'b101}) begin
            n_bad++; $display("FAIL ovf_rne_inf got %h/%0d/%b want 0/2047/101", f, e, fl);
        end
        // RUP on a negative value gives inc = 0, so the result stays at max finite and does not overflow.
        run_op(ONES, 1'b1, 1'b0, 13'd2046, 1'b1, 3'b011, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {ONES, 11'd2046, 3'b001}) begin
            n_bad++; $display("FAIL ovf_rup_neg got %h/%0d/%b want fffffffffffff/2046/001", f, e, fl);
        end
        run_op(52'h0, 1'b0, 1'b1, 13'd2047, 1'b0, 3'b001, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {ONES, 11'd2046, 3'b101}) begin
            n_bad++; $display("FAIL ovf_rtz_maxfin got %h/%0d/%b want fffffffffffff/2046/101", f, e, fl);
        end
        run_op(ONES, 1'b1, 1'b0, 13'd2046, 1'b0, 3'b011, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h0, 11'd2047, 3'b101}) begin
            n_bad++; $display("FAIL ovf_rup_pos got %h/%0d/%b want 0/2047/101", f, e, fl);
        end
    endtask

    task automatic test_underflow;
        logic [51:0] f; logic [10:0] e; logic sg; logic [2:0] fl; int lat;
        run_op(52'h10, 1'b0, 1'b1, 13'd0, 1'b0, 3'b000, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h10, 11'd0, 3'b011}) begin
            n_bad++; $display("FAIL uf_inexact got %h/%0d/%b want 10/0/011", f, e, fl);
        end
        run_op(ONES, 1'b1, 1'b0, 13'd0, 1'b0, 3'b100, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h0, 11'd1, 3'b001}) begin
            n_bad++; $display("FAIL uf_carry_norm got %h/%0d/%b want 0/1/001", f, e, fl);
        end
        run_op(52'h10, 1'b0, 1'b0, 13'd0, 1'b0, 3'b000, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, fl} !== {52'h10, 11'd0, 3'b000}) begin
            n_bad++; $display("FAIL uf_exact got %h/%0d/%b want 10/0/000", f, e, fl);
        end
    endtask

    // Five ops streamed back to back while out_ready follows 1,0,0,1,1.
    task automatic test_back_to_back;
        logic [4:0]  pat;
        int          sent, got, cyc;
        logic        held;
        logic [51:0] held_frac;
        logic        exp_ready;
        pat = 5'b11001;
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_frac = '0;
        @(negedge clk);
        while (got < 5 && cyc < 40) begin
            out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
            in_valid  = (sent < 5);
            in_v      = {52'(sent + 1), 2'b00};
            in_exp    = 13'(100 + sent);
            in_sign   = 1'b0;
            in_frm    = 3'b001;
            #1;
            exp_ready = out_ready | ((sent - got) < 2);
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_bad++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready);
            end
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_frac !== held_frac) begin
                    n_bad++; $display("FAIL b2b_stall_hold got %b/%h want 1/%h", out_valid, out_frac, held_frac);
                end
            end
            held = out_valid & ~out_ready;
            held_frac = out_frac;
            if (out_valid && out_ready) begin
                n_cmp++;
                if ({out_frac, out_exp} !== {52'(got + 1), 11'(100 + got)}) begin
                    n_bad++; $display("FAIL b2b_order got %h/%0d want %0d/%0d", out_frac, out_exp, got + 1, 100 + got);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got !== 5) begin n_bad++; $display("FAIL b2b_count got %0d want 5", got); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        logic [51:0] f; logic [10:0] e; logic sg; logic [2:0] fl; int lat;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_v = {52'hA, 2'b00}; in_exp = 13'd10; in_frm = 3'b001;
        @(negedge clk);
        in_v = {52'hB, 2'b00};
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_bad++; $display("FAIL flush_prefill valid/ready got %b want 10", {out_valid, in_ready});
        end
        flush = 1'b1; in_v = {52'hC, 2'b00};
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL flush_clear valid/ready got %b want 01", {out_valid, in_ready});
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_capture got %b want 0", out_valid); end
        run_op(52'hD, 1'b0, 1'b0, 13'd20, 1'b0, 3'b001, f, e, sg, fl, lat);
        n_cmp++;
        if ({f, e, lat} !== {52'hD, 11'd20, 32'd2}) begin
            n_bad++; $display("FAIL flush_next got %h/%0d lat %0d want d/20 lat 2", f, e, lat);
        end
    endtask

    task automatic test_reset_mid_stall;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_v = {52'hE, 2'b00}; in_exp = 13'd30; in_frm = 3'b000;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_frac} !== 53'd0) begin
            n_bad++; $display("FAIL reset_mid_stall got %b/%h want 0/0", out_valid, out_frac);
        end
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL reset_mid_stall_after got %b want 01", {out_valid, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_rne();
        test_carry();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
